// File: rtl/truth_table_sweeper_pkg.sv
// Shared definitions for the truth-table sweeper.
// Contents: controller state encoding and a constant clog2 helper used
// to size the dwell counter.
package truth_table_sweeper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_HOLD    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Smallest r with 2**r >= value; evaluated at elaboration time.
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_lut.sv
// Registered N_IN-input lookup table.
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset, clears f
//   lut_table  2**N_IN-bit function table, bit k = F(k)
//   vec        input vector selecting the table bit
//   f          registered F(vec), one cycle of latency
module lut_eval #(
    parameter int N_IN = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [2**N_IN-1:0]   lut_table,
    input  logic [N_IN-1:0]      vec,
    output logic                 f
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f <= 1'b0;
        end else begin
            f <= lut_table[vec];
        end
    end

endmodule

// File: rtl/truth_table_sweeper.sv
// Programmable Boolean function evaluator with an exhaustive self-sweep.
// Manual mode evaluates the table on manual_in; sweep mode walks every
// input vector, holds it for DWELL cycles, captures F and counts
// disagreements with the expected table.
// Ports:
//   clk, reset       system clock, asynchronous active-high reset
//   start, mode      sweep request (IDLE only) and mode select (1 = sweep)
//   manual_in        live input vector for manual mode
//   truth_table      function table, bit k = F(k)
//   expected         reference table for the sweep comparison
//   vec_out, f_out   vector currently applied and registered F(vec_out)
//   busy, done       sweep in progress / one-cycle end-of-sweep pulse
//   captured         per-vector captured F bits
//   mismatch_count   vectors where captured != expected
//   pass             mismatch_count == 0, valid from done until next start
//
// state   | meaning
// IDLE    | manual evaluation, waiting for a sweep request
// APPLY   | drive the current index onto vec_out, load dwell counter
// HOLD    | let the function settle for DWELL cycles
// CAPTURE | record f_out, compare against expected, advance index
// DONE    | one-cycle done pulse, then back to IDLE
module truth_table_sweeper
    import truth_table_sweeper_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int DWELL = 10,
    parameter int CNT_W = clog2_f(DWELL + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [N_IN-1:0]      manual_in,
    input  logic [2**N_IN-1:0]   truth_table,
    input  logic [2**N_IN-1:0]   expected,
    output logic [N_IN-1:0]      vec_out,
    output logic                 f_out,
    output logic                 busy,
    output logic                 done,
    output logic [2**N_IN-1:0]   captured,
    output logic [N_IN:0]        mismatch_count,
    output logic                 pass
);

    localparam int              N_VEC    = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(N_VEC - 1);

    state_t             state;
    logic [N_IN-1:0]    idx;
    logic [CNT_W-1:0]   dwell_cnt;
    logic [N_VEC-1:0]   tt_q;
    logic [N_VEC-1:0]   exp_q;
    logic [N_VEC-1:0]   table_sel;
    logic [N_IN:0]      mm_next;

    // Live table while idle so manual mode tracks the switches; the
    // latched copy during a sweep so table edits cannot disturb it.
    assign table_sel = (state == ST_IDLE) ? truth_table : tt_q;

    assign mm_next = mismatch_count + {{N_IN{1'b0}}, (f_out != exp_q[idx])};

    lut_eval #(
        .N_IN (N_IN)
    ) u_lut (
        .clk       (clk),
        .reset     (reset),
        .lut_table (table_sel),
        .vec       (vec_out),
        .f         (f_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            idx            <= '0;
            dwell_cnt      <= '0;
            tt_q           <= '0;
            exp_q          <= '0;
            vec_out        <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            captured       <= '0;
            mismatch_count <= '0;
            pass           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    vec_out <= manual_in;
                    if (start && mode) begin
                        state          <= ST_APPLY;
                        busy           <= 1'b1;
                        tt_q           <= truth_table;
                        exp_q          <= expected;
                        idx            <= '0;
                        captured       <= '0;
                        mismatch_count <= '0;
                        pass           <= 1'b0;
                    end
                end
                ST_APPLY: begin
                    vec_out   <= idx;
                    dwell_cnt <= CNT_W'(DWELL - 1);
                    state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (dwell_cnt == '0) begin
                        state <= ST_CAPTURE;
                    end else begin
                        dwell_cnt <= dwell_cnt - 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    captured[idx]  <= f_out;
                    mismatch_count <= mm_next;
                    if (idx == LAST_IDX) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                        // Use the count including this last vector so pass
                        // is already valid in the done cycle.
                        pass  <= (mm_next == '0);
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_APPLY;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
module tb_truth_table_sweeper;

    localparam int N_IN     = 3;
    localparam int DWELL    = 2;
    localparam int NV       = 8;
    localparam int PER      = DWELL + 2;
    localparam int DONE_OFF = 1 + NV * PER;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] manual_in = '0;
    logic [7:0] truth_table = '0;
    logic [7:0] expected = '0;
    logic [2:0] vec_out;
    logic       f_out;
    logic       busy;
    logic       done;
    logic [7:0] captured;
    logic [3:0] mismatch_count;
    logic       pass;

    int total = 0;
    int bad = 0;
    bit rand_man = 1'b0;

    always #5 clk = ~clk;

    truth_table_sweeper #(
        .N_IN  (N_IN),
        .DWELL (DWELL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .mode           (mode),
        .manual_in      (manual_in),
        .truth_table    (truth_table),
        .expected       (expected),
        .vec_out        (vec_out),
        .f_out          (f_out),
        .busy           (busy),
        .done           (done),
        .captured       (captured),
        .mismatch_count (mismatch_count),
        .pass           (pass)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Behavioural model: a sweep is a timeline measured in cycles since the
    // accepted start; manual mode is a two-deep pipeline of manual_in.
    bit         m_sweeping = 1'b0;
    bit         m_ran = 1'b0;
    int         m_off = 0;
    int         m_idle_edges = 0;
    logic [7:0] m_tt = '0;
    logic [7:0] m_ex = '0;
    logic [2:0] m_prev_man = '0;
    logic       m_exp_f = 1'b0;
    bit         m_idle_now;

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_sweeping   = 1'b0;
                m_ran        = 1'b0;
                m_off        = 0;
                m_idle_edges = 0;
                m_prev_man   = '0;
                m_exp_f      = 1'b0;
            end else begin
                m_idle_now = !m_sweeping || (m_off > DONE_OFF);
                m_exp_f    = truth_table[m_prev_man];
                m_prev_man = manual_in;
                if (m_idle_now && start && mode) begin
                    m_sweeping   = 1'b1;
                    m_ran        = 1'b1;
                    m_off        = 1;
                    m_tt         = truth_table;
                    m_ex         = expected;
                    m_idle_edges = 0;
                end else begin
                    if (m_sweeping) m_off++;
                    if (m_idle_now) m_idle_edges++;
                    else m_idle_edges = 0;
                end
            end
        end
    end

    int         c_ncap;
    logic [8:0] c_mask;
    logic [7:0] c_cap;
    int         c_mm;
    bit         c_pass;
    bit         c_busy;

    initial begin
        forever begin
            @(negedge clk);
            c_busy = m_sweeping && (m_off >= 1) && (m_off <= DONE_OFF);
            chk("busy", busy, c_busy);
            chk("done", done, m_sweeping && (m_off == DONE_OFF));
            if (m_ran) begin
                c_ncap = (m_off - 1) / PER;
                if (c_ncap > NV) c_ncap = NV;
                c_mask = (9'd1 << c_ncap) - 9'd1;
                c_cap  = m_tt & c_mask[7:0];
                c_mm   = $countones((m_tt ^ m_ex) & c_mask[7:0]);
                c_pass = (m_off >= DONE_OFF) && (c_mm == 0);
            end else begin
                c_cap  = '0;
                c_mm   = 0;
                c_pass = 1'b0;
            end
            chk("captured", captured, c_cap);
            chk("mismatch_count", mismatch_count, c_mm);
            chk("pass", pass, c_pass);
            if (reset) begin
                chk("reset_vec", vec_out, 0);
                chk("reset_f", f_out, 0);
            end else if (c_busy) begin
                if (m_off >= 2) chk("sweep_vec", vec_out, (m_off - 2) / PER);
                if (m_off >= 3) chk("sweep_f", f_out, m_tt[(m_off - 3) / PER]);
            end else if (m_idle_edges >= 1) begin
                chk("manual_vec", vec_out, m_prev_man);
                if (m_idle_edges >= 2) chk("manual_f", f_out, m_exp_f);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (rand_man) manual_in = 3'($urandom);
        end
    endtask

    task automatic sweep(input logic [7:0] tt, input logic [7:0] ex,
                         input bit interfere, output int n);
        truth_table = tt;
        expected    = ex;
        mode        = 1'b1;
        start       = 1'b1;
        cyc(1);
        start = 1'b0;
        n = 1;
        while (!done && n < 100) begin
            if (interfere && n == 10) begin
                start       = 1'b1;
                mode        = 1'b0;
                truth_table = 8'h00;
                expected    = 8'hFF;
            end else if (interfere && n == 11) begin
                start = 1'b0;
            end
            cyc(1);
            n++;
        end
        start = 1'b0;
    endtask

    int n;
    int seen;
    logic [7:0] r_tt;
    logic [7:0] r_ex;

    initial begin
        #1 reset = 1'b1;
        cyc(3);
        reset = 1'b0;
        cyc(1);
        chk("reset_captured_lit", captured, 0);
        chk("reset_busy_lit", busy, 0);

        // Manual mode
        mode        = 1'b0;
        truth_table = 8'hE4;
        manual_in   = 3'd2;
        cyc(2);
        chk("manual_f_2_lit", f_out, 1);
        manual_in = 3'd0;
        cyc(2);
        chk("manual_f_0_lit", f_out, 0);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        chk("manual_start_ignored", busy, 0);

        // Clean sweep, then a start in the done cycle must be ignored
        sweep(8'hE4, 8'hE4, 1'b0, n);
        chk("clean_done_cycle", n, DONE_OFF);
        chk("clean_captured_lit", captured, 8'hE4);
        chk("clean_mm_lit", mismatch_count, 0);
        chk("clean_pass_lit", pass, 1);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("start_in_done_ignored", busy, 0);
        cyc(3);
        chk("clean_pass_hold", pass, 1);

        // Faulty sweep
        sweep(8'hE4, 8'hE5, 1'b0, n);
        chk("faulty_done_cycle", n, DONE_OFF);
        chk("faulty_captured_lit", captured, 8'hE4);
        chk("faulty_mm_lit", mismatch_count, 1);
        chk("faulty_pass_lit", pass, 0);
        cyc(2);

        // Mid-sweep interference
        sweep(8'hE4, 8'hE4, 1'b1, n);
        chk("interf_done_cycle", n, DONE_OFF);
        chk("interf_captured_lit", captured, 8'hE4);
        chk("interf_pass_lit", pass, 1);
        cyc(2);

        // Reset mid-sweep
        truth_table = 8'h1B;
        expected    = 8'h00;
        mode        = 1'b1;
        start       = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(9);
        chk("pre_reset_captured_lit", captured, 8'h03);
        chk("pre_reset_mm_lit", mismatch_count, 2);
        #2 reset = 1'b1;
        #1;
        chk("async_busy", busy, 0);
        chk("async_vec", vec_out, 0);
        chk("async_f", f_out, 0);
        chk("async_captured", captured, 0);
        chk("async_mm", mismatch_count, 0);
        chk("async_pass", pass, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (done) seen++;
        end
        chk("no_done_after_reset", seen, 0);
        sweep(8'h1B, 8'h1B, 1'b0, n);
        chk("post_reset_done_cycle", n, DONE_OFF);
        chk("post_reset_captured", captured, 8'h1B);
        chk("post_reset_pass", pass, 1);
        cyc(2);

        // Random manual evaluation
        rand_man    = 1'b1;
        mode        = 1'b0;
        truth_table = 8'($urandom);
        cyc(20);

        // Random sweeps
        for (int k = 0; k < 20; k++) begin
            r_tt = 8'($urandom);
            r_ex = (k % 3 == 0) ? r_tt : 8'($urandom);
            sweep(r_tt, r_ex, 1'b0, n);
            chk("rand_done_cycle", n, DONE_OFF);
            chk("rand_captured", captured, r_tt);
            chk("rand_mm", mismatch_count, $countones(r_tt ^ r_ex));
            chk("rand_pass", pass, (r_tt == r_ex));
            cyc(2 + ($urandom % 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Parametrised hardware successor to our hand-written exhaustive-stimulus benches.
- Evaluates a programmable N-input Boolean function, stored as a 2^N-bit truth table, on live inputs (manual mode).
- Sweep mode: autonomously walks all 2^N input vectors with a fixed dwell per vector, captures each output bit and counts mismatches against an expected table.
- Sits between board switches/LEDs and lab function logic on the Basys3 top level; doubles as an on-chip self-checker.

Parameters:
- N_IN, 3, number of function inputs (1..6).
- DWELL, 10, hold cycles per vector before capture (>=1).
- CNT_W, $clog2(DWELL+1), dwell counter width (derived; do not override).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle request; honoured only in IDLE with mode=1.
- mode  in  1  0 = manual evaluate, 1 = sweep; sampled only in IDLE.
- manual_in  in  N_IN  input vector for manual mode.
- truth_table  in  2^N_IN  bit k = F for input vector k.
- expected  in  2^N_IN  reference table for sweep comparison.
- vec_out  out  N_IN  vector currently applied.
- f_out  out  1  registered function output.
- busy  out  1  high in APPLY/HOLD/CAPTURE/DONE.
- done  out  1  high exactly one cycle at sweep end.
- captured  out  2^N_IN  per-vector captured F bits.
- mismatch_count  out  N_IN+1  number of vectors where captured != expected.
- pass  out  1  mismatch_count==0; valid from done until next start.

Behaviour:
- Reset (async, any state): state=IDLE, all outputs 0, internal idx/dwell counter/latched tables 0.
- f_out = table_sel[vec_out] registered (1-cycle latency). table_sel = truth_table in IDLE, latched copy otherwise.
- IDLE:
  - vec_out <= manual_in, so f_out follows manual_in with 2-cycle latency.
  - start & mode=1 -> APPLY. On that edge: latch truth_table and expected, idx=0, clear captured, mismatch_count and pass.
  - start & mode=0 is ignored.
- APPLY (1 cycle): vec_out <= idx, dwell counter <= DWELL-1 -> HOLD.
- HOLD (DWELL cycles): decrement; at 0 -> CAPTURE. f_out is valid for idx by CAPTURE because DWELL>=1.
- CAPTURE (1 cycle): captured[idx] <= f_out; if f_out != exp_q[idx], mismatch_count++.
  - idx == 2^N_IN-1 -> DONE; else idx++ -> APPLY.
- DONE (1 cycle): done=1, pass <= (final mismatch_count==0) -> IDLE.
- Timing: per vector DWELL+2 cycles. done is high in cycle t+1+2^N_IN*(DWELL+2), where t is the start-sampling cycle.
- captured, mismatch_count and pass hold after DONE until the next accepted start or reset.
- Boundaries:
  - start while busy: ignored, no restart.
  - mode, truth_table or expected changing mid-sweep: no effect (latched/sampled).
  - idx wrap: none; the sweep terminates at the last vector.
  - mismatch_count cannot overflow (max 2^N_IN fits in N_IN+1 bits).
  - Reset mid-sweep: immediate abort to IDLE with all outputs 0; no done pulse.
  - start asserted in the DONE cycle: ignored. A sweep must be requested from IDLE.

Decomposition:
- Shared package: state encoding constants (IDLE, APPLY, HOLD, CAPTURE, DONE) and a clog2 helper for CNT_W.
- One sub-module: lut_eval (registered N_IN-input LUT: clk, reset, table, vec -> f). Reused by other lab blocks needing programmable functions.

Test Plan (N_IN=3, DWELL=2, per-vector 4 cycles):
- Manual: mode=0, truth_table=8'hE4, manual_in=3'd2 -> f_out=1 two cycles later. manual_in=3'd0 -> f_out=0. busy stays 0.
- Clean sweep: truth_table=8'hE4, expected=8'hE4, start pulse -> vec_out steps 0..7, one vector per 4 cycles. done high exactly once, 33 cycles after start; captured=8'hE4, mismatch_count=0, pass=1.
- Faulty sweep: truth_table=8'hE4, expected=8'hE5 -> captured=8'hE4, mismatch_count=1, pass=0 at done.
- Mid-sweep interference: during the sweep, pulse start, flip mode to 0, change truth_table to 8'h00 -> sweep unaffected; captured=8'hE4, done at same cycle.
- Reset mid-sweep: assert reset at cycle 10 after start -> asynchronously all outputs 0, state IDLE, no done. A subsequent start yields a full correct sweep.
- Exhaustive random: 20 random truth_table/expected pairs -> captured==truth_table and mismatch_count==popcount(truth_table^expected) each run.
